bus_skew_meter: RTL and testbench

Synthesizable skew and valid-window meter for a parallel pad bus such as PSRAM DQ plus RWDS. It sits downstream of the pad oversampling register, which supplies one known-valid bus sample per strobe. It groups bit transitions into bursts, then measures each burst's skew (first-to-last edge spread) and the stable window before it. Each burst produces one result on a valid/ready port, and running worst-case statistics are exposed for CSR readout.

---
 rtl/bus_skew_meter_pkg.sv | 9 +
 rtl/sat_cnt.sv | 24 ++
 rtl/bus_skew_meter.sv | 150 +++++++++++++++
 tb/tb_bus_skew_meter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_skew_meter_pkg.sv
// bus_skew_meter_pkg: shared FSM state type and violation bit positions.
package bus_skew_meter_pkg;

    typedef enum logic [1:0] {IDLE, BURST, STABLE} state_t;

    localparam int VIOL_SKEW = 0;
    localparam int VIOL_WIN  = 1;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: up-counter that sticks at all-ones; clear beats load beats increment.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) r_q <= '0;
        else if (i_load) r_q <= i_load_val;
        else if (i_inc && r_q != '1) r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/bus_skew_meter.sv
// bus_skew_meter: groups bus edges into bursts and reports each burst's edge spread
// and the stable window before it, plus running worst-case statistics.
module bus_skew_meter
    import bus_skew_meter_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int TS_W       = 8,
    parameter int GAP        = 4,
    parameter int SKEW_LIMIT = 2,
    parameter int WIN_LIMIT  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             clear_stats,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TS_W-1:0]  res_skew,
    output logic [TS_W-1:0]  res_window,
    output logic             res_win_vld,
    output logic [1:0]       res_viol,
    output logic [TS_W-1:0]  max_skew,
    output logic [TS_W-1:0]  min_window,
    output logic [15:0]      burst_cnt,
    output logic [15:0]      viol_cnt,
    output logic             res_ovf
);

    localparam logic [TS_W-1:0] MAXV = '1;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_prev;
    logic             r_pv, r_wv;
    logic [TS_W-1:0]  r_skew, r_wlat;
    logic             r_res_valid, r_res_win_vld, r_res_ovf;
    logic [TS_W-1:0]  r_res_skew, r_res_window, r_max_skew, r_min_window;
    logic [1:0]       r_res_viol, w_viol;
    logic             w_take, w_chg, w_bs, w_ss, w_start, w_close, w_hold;
    logic [TS_W-1:0]  w_span, w_quiet, w_win, w_span_nx, w_win_nx;

    assign w_take    = enable && din_vld;
    assign w_chg     = w_take && r_pv && ((din ^ r_prev) != '0);
    assign w_bs      = w_take && r_pv && r_state == BURST;
    assign w_ss      = w_take && r_pv && r_state == STABLE;
    assign w_start   = w_chg && r_state != BURST;
    assign w_close   = w_bs && !w_chg && w_quiet == TS_W'(GAP - 1);
    assign w_hold    = r_res_valid && !res_ready;
    // Counters hold the interval count up to the previous sample; +1 counts the current one.
    assign w_span_nx = (w_span == MAXV) ? MAXV : w_span + 1'b1;
    assign w_win_nx  = (w_win == MAXV) ? MAXV : w_win + 1'b1;

    always_comb begin
        w_viol            = '0;
        w_viol[VIOL_SKEW] = r_skew > TS_W'(SKEW_LIMIT);
        w_viol[VIOL_WIN]  = r_wv && r_wlat < TS_W'(WIN_LIMIT);
    end

    sat_cnt #(.W(TS_W)) u_span (
        .clk(clk), .rst(rst), .i_inc(w_bs), .i_clr(w_start),
        .i_load(1'b0), .i_load_val('0), .o_q(w_span)
    );

    sat_cnt #(.W(TS_W)) u_quiet (
        .clk(clk), .rst(rst), .i_inc(w_bs && !w_chg), .i_clr(w_start || (w_bs && w_chg)),
        .i_load(1'b0), .i_load_val('0), .o_q(w_quiet)
    );

    sat_cnt #(.W(TS_W)) u_win (
        .clk(clk), .rst(rst), .i_inc(w_ss && !w_chg), .i_clr(1'b0),
        .i_load(w_close), .i_load_val(TS_W'(GAP)), .o_q(w_win)
    );

    sat_cnt #(.W(16)) u_burst_cnt (
        .clk(clk), .rst(rst), .i_inc(w_close), .i_clr(clear_stats),
        .i_load(1'b0), .i_load_val('0), .o_q(burst_cnt)
    );

    sat_cnt #(.W(16)) u_viol_cnt (
        .clk(clk), .rst(rst), .i_inc(w_close && w_viol != '0), .i_clr(clear_stats),
        .i_load(1'b0), .i_load_val('0), .o_q(viol_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Dropping enable (chip select) ends the session from any state.
    always_comb begin
        w_next = r_state;
        w_next = !enable ? IDLE : w_start ? BURST : w_close ? STABLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev        <= '0;
            r_pv          <= 1'b0;
            r_skew        <= '0;
            r_wlat        <= '0;
            r_wv          <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_skew    <= '0;
            r_res_window  <= '0;
            r_res_win_vld <= 1'b0;
            r_res_viol    <= '0;
            r_max_skew    <= '0;
            r_min_window  <= '1;
            r_res_ovf     <= 1'b0;
        end else begin
            if (!enable) r_pv <= 1'b0;
            else if (din_vld) begin
                r_prev <= din;
                r_pv   <= 1'b1;
            end
            if (w_start) begin
                r_skew <= '0;
                r_wv   <= r_state == STABLE;
                r_wlat <= (r_state == STABLE) ? w_win_nx : '0;
            end else if (w_bs && w_chg) r_skew <= w_span_nx;
            if (w_close && !w_hold) begin
                r_res_valid   <= 1'b1;
                r_res_skew    <= r_skew;
                r_res_window  <= r_wlat;
                r_res_win_vld <= r_wv;
                r_res_viol    <= w_viol;
            end else if (res_ready) r_res_valid <= 1'b0;
            if (clear_stats) begin
                r_max_skew   <= '0;
                r_min_window <= '1;
                r_res_ovf    <= 1'b0;
            end else if (w_close) begin
                if (r_skew > r_max_skew) r_max_skew <= r_skew;
                if (r_wv && r_wlat < r_min_window) r_min_window <= r_wlat;
                if (w_hold) r_res_ovf <= 1'b1;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_skew    = r_res_skew;
    assign res_window  = r_res_window;
    assign res_win_vld = r_res_win_vld;
    assign res_viol    = r_res_viol;
    assign max_skew    = r_max_skew;
    assign min_window  = r_min_window;
    assign res_ovf     = r_res_ovf;

endmodule

// File: tb/tb_bus_skew_meter.sv
// tb_bus_skew_meter: directed scenarios plus random traffic, checked by a scoreboard
// fed from an edge-index reference model of bursts and windows.
module tb_bus_skew_meter;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst, enable, din_vld, clear_stats, res_ready;
    logic [17:0] din;
    logic        res_valid, res_win_vld, res_ovf;
    logic [7:0]  res_skew, res_window, max_skew, min_window;
    logic [1:0]  res_viol;
    logic [15:0] burst_cnt, viol_cnt;

    bus_skew_meter dut (
        .clk(clk), .rst(rst), .enable(enable), .din(din), .din_vld(din_vld),
        .clear_stats(clear_stats), .res_valid(res_valid), .res_ready(res_ready),
        .res_skew(res_skew), .res_window(res_window), .res_win_vld(res_win_vld),
        .res_viol(res_viol), .max_skew(max_skew), .min_window(min_window),
        .burst_cnt(burst_cnt), .viol_cnt(viol_cnt), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {int skew; int win; int wv; int viol;} res_t;
    res_t q[$];

    int n_vec = 0, n_bad = 0;
    bit mon_on = 0;
    logic g_rst = 1'b1, g_rdy = 1'b1, g_clr = 1'b0;
    logic [17:0] g_d = '0;

    // Reference model: sample index n within an enable session; edges tracked by index.
    logic [17:0] m_prev;
    bit m_pv, m_inb, m_hp, m_wv, m_ovf;
    int m_n, m_first, m_last, m_plast, m_win, m_max, m_min, m_bc, m_vc;

    function automatic int sat8(int x);
        return x > 255 ? 255 : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_close(input logic rdy);
        res_t r;
        r.skew = sat8(m_last - m_first);
        r.win  = m_win;
        r.wv   = m_wv;
        r.viol = (r.skew > 2 ? 1 : 0) | ((m_wv && m_win < 8) ? 2 : 0);
        if (q.size() != 0 && !rdy) m_ovf = 1;
        else q.push_back(r);
        if (r.skew > m_max) m_max = r.skew;
        if (m_wv && m_win < m_min) m_min = m_win;
        if (m_bc < 65535) m_bc++;
        if (r.viol != 0 && m_vc < 65535) m_vc++;
        m_inb = 0;
        m_hp = 1;
        m_plast = m_last;
    endtask

    task automatic model(input logic r, e, v, input logic [17:0] d, input logic rdy, clr);
        if (r) begin
            q.delete();
            m_pv = 0; m_inb = 0; m_hp = 0; m_ovf = 0;
            m_max = 0; m_min = 255; m_bc = 0; m_vc = 0;
            return;
        end
        if (!e) begin
            m_pv = 0; m_inb = 0; m_hp = 0;
        end else if (v) begin
            if (!m_pv) begin
                m_pv = 1;
                m_n = 0;
            end else begin
                m_n++;
                if (d != m_prev) begin
                    if (!m_inb) begin
                        m_inb = 1;
                        m_first = m_n;
                        m_wv = m_hp;
                        m_win = m_hp ? sat8(m_n - m_plast) : 0;
                    end
                    m_last = m_n;
                end else if (m_inb && m_n - m_last == GAP) model_close(rdy);
            end
            m_prev = d;
        end
        if (clr) begin
            m_max = 0; m_min = 255; m_bc = 0; m_vc = 0; m_ovf = 0;
        end
    endtask

    task automatic step(input logic e, v, input logic [17:0] d);
        rst = g_rst; enable = e; din_vld = v; din = d;
        res_ready = g_rdy; clear_stats = g_clr;
        @(posedge clk);
        #1;
        model(g_rst, e, v, d, g_rdy, g_clr);
    endtask

    task automatic stable(input int k, input logic [17:0] d);
        for (int i = 0; i < k; i++) step(1'b1, 1'b1, d);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("res_valid", res_valid, q.size() != 0);
            if (res_valid && res_ready && q.size() != 0) begin
                res_t e;
                e = q.pop_front();
                chk("sb_skew", res_skew, e.skew);
                chk("sb_window", res_window, e.win);
                chk("sb_win_vld", res_win_vld, e.wv);
                chk("sb_viol", res_viol, e.viol);
            end
            chk("max_skew", max_skew, m_max);
            chk("min_window", min_window, m_min);
            chk("burst_cnt", burst_cnt, m_bc);
            chk("viol_cnt", viol_cnt, m_vc);
            chk("res_ovf", res_ovf, m_ovf);
        end
    end

    initial begin
        g_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            g_rdy = 1'($urandom); g_clr = 1'($urandom);
            step(1'($urandom), 1'($urandom), 18'($urandom));
        end
        chk("rst_valid", res_valid, 0);
        chk("rst_skew", res_skew, 0);
        chk("rst_window", res_window, 0);
        chk("rst_win_vld", res_win_vld, 0);
        chk("rst_viol", res_viol, 0);
        chk("rst_max_skew", max_skew, 0);
        chk("rst_min_window", min_window, 255);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        chk("rst_ovf", res_ovf, 0);
        g_rst = 1'b0; g_rdy = 1'b1; g_clr = 1'b0;
        mon_on = 1;

        stable(3, 18'h00000);
        stable(2, 18'h00001);
        stable(5, 18'h00021);
        chk("b1_valid", res_valid, 1);
        chk("b1_skew", res_skew, 2);
        chk("b1_win_vld", res_win_vld, 0);
        chk("b1_viol", res_viol, 0);
        chk("b1_burst_cnt", burst_cnt, 1);
        chk("b1_max_skew", max_skew, 2);
        stable(5, 18'h00021);
        stable(3, 18'h00029);
        stable(5, 18'h0002B);
        chk("b2_skew", res_skew, 3);
        chk("b2_window", res_window, 10);
        chk("b2_win_vld", res_win_vld, 1);
        chk("b2_viol", res_viol, 1);
        chk("b2_viol_cnt", viol_cnt, 1);
        chk("b2_min_window", min_window, 10);

        stable(5, 18'h0002B);
        stable(1, 18'h0002F);
        stable(5, 18'h00027);
        chk("b3_skew", res_skew, 1);
        chk("b3_window", res_window, 10);
        stable(5, 18'h00026);
        chk("narrow_window", res_window, 5);
        chk("narrow_viol", res_viol, 2);
        chk("narrow_viol_cnt", viol_cnt, 2);
        chk("narrow_min_window", min_window, 5);

        g_clr = 1'b1; stable(1, 18'h00026); g_clr = 1'b0;
        g_rdy = 1'b0;
        stable(3, 18'h00026);
        stable(1, 18'h00036);
        stable(5, 18'h00037);
        chk("bp_a_valid", res_valid, 1);
        chk("bp_a_skew", res_skew, 1);
        stable(6, 18'h00037);
        stable(5, 18'h0003F);
        chk("bp_held_valid", res_valid, 1);
        chk("bp_held_skew", res_skew, 1);
        chk("bp_ovf", res_ovf, 1);
        chk("bp_burst_cnt", burst_cnt, 2);
        g_rdy = 1'b1;
        stable(1, 18'h0003F);
        chk("bp_accepted", res_valid, 0);
        g_clr = 1'b1; stable(1, 18'h0003F); g_clr = 1'b0;
        chk("clr_ovf", res_ovf, 0);
        chk("clr_burst_cnt", burst_cnt, 0);
        chk("clr_viol_cnt", viol_cnt, 0);
        chk("clr_max_skew", max_skew, 0);
        chk("clr_min_window", min_window, 255);

        stable(2, 18'h0003F);
        stable(1, 18'h0003E);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 18'h0003E);
        chk("abort_valid", res_valid, 0);
        chk("abort_burst_cnt", burst_cnt, 0);
        stable(2, 18'h0003E);
        stable(5, 18'h0003C);
        chk("reen_valid", res_valid, 1);
        chk("reen_skew", res_skew, 0);
        chk("reen_win_vld", res_win_vld, 0);
        chk("reen_burst_cnt", burst_cnt, 1);

        stable(300, 18'h0003C);
        stable(5, 18'h0001C);
        chk("sat_window", res_window, 255);
        chk("sat_win_vld", res_win_vld, 1);
        chk("sat_viol", res_viol, 0);

        g_d = 18'h0001C;
        for (int i = 0; i < 4000; i++) begin
            logic e, v;
            e = $urandom_range(59) != 0;
            v = $urandom_range(3) != 0;
            if ($urandom_range(5) == 0) g_d = g_d ^ (18'd1 << $urandom_range(17));
            if ($urandom_range(15) == 0) g_d = g_d ^ 18'($urandom);
            g_rdy = $urandom_range(9) < 7;
            g_clr = $urandom_range(199) == 0;
            step(e, v, g_d);
        end
        g_rdy = 1'b1; g_clr = 1'b0;
        stable(5, g_d);
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
